// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the 8-channel, 4-bit mux scan controller.
// Channel count must stay a power of two so the select counter wraps naturally.
package mux_scan_pkg;

   localparam int NBITS  = 4;
   localparam int NCHANS = 8;
   localparam int SEL_W  = $clog2(NCHANS);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
      return s + 1'b1;
   endfunction

endpackage

// File: rtl/mux_scan_outbuf.sv
// Single-entry val/rdy output register: load wins over drain, otherwise hold.
// space_o tells the producer a load this cycle will not overwrite an unsent sample.
module mux_scan_outbuf
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [SEL_W-1:0] chan_i,
   input  logic [NBITS-1:0] data_i,
   input  logic             rdy_i,
   output logic             val_o,
   output logic [SEL_W-1:0] chan_o,
   output logic [NBITS-1:0] data_o,
   output logic             space_o
);

   logic             val_q,  val_d;
   logic [SEL_W-1:0] chan_q, chan_d;
   logic [NBITS-1:0] data_q, data_d;

   always_comb begin
      val_d  = val_q;
      chan_d = chan_q;
      data_d = data_q;
      if (load_i) begin
         val_d  = 1'b1;
         chan_d = chan_i;
         data_d = data_i;
      end else if (val_q && rdy_i) begin
         val_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_q  <= 1'b0;
         chan_q <= '0;
         data_q <= '0;
      end else begin
         val_q  <= val_d;
         chan_q <= chan_d;
         data_q <= data_d;
      end
   end

   assign val_o   = val_q;
   assign chan_o  = chan_q;
   assign data_o  = data_q;
   assign space_o = !val_q || rdy_i;

endmodule

// File: rtl/mux_scan_ctrl_4b_8ch.sv
// Scan controller: walks the mux select over enabled channels and streams each
// sample out through a one-deep val/rdy buffer, pulsing frame_done on wrap.
module mux_scan_ctrl_4b_8ch
   import mux_scan_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [NCHANS-1:0] mask,
   output logic [SEL_W-1:0]  sel,
   input  logic [NBITS-1:0]  mux_out,
   output logic              out_val,
   input  logic              out_rdy,
   output logic [SEL_W-1:0]  out_chan,
   output logic [NBITS-1:0]  out_data,
   output logic              frame_done,
   output logic              busy
);

   scan_state_t      state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             frame_done_q, frame_done_d;

   logic scan_en;
   logic hit;
   logic space;
   logic cap;
   logic adv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = '0;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE:    state_d = en ? SCAN : IDLE;
         SCAN:    state_d = en ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
      // Leaving SCAN or sitting in IDLE parks the select at channel 0.
      if (adv) begin
         sel_d        = sel_inc(sel_q);
         frame_done_d = (sel_q == SEL_W'(NCHANS - 1));
      end else if (scan_en) begin
         sel_d        = sel_q;
      end
   end

   always_comb begin
      scan_en = (state_q == SCAN) && en;
      hit     = mask[sel_q];
      cap     = scan_en && hit && space;
      adv     = cap || (scan_en && !hit);
      busy    = (state_q == SCAN) || out_val;
   end

   mux_scan_outbuf u_outbuf (
      .clk     (clk),
      .reset   (reset),
      .load_i  (cap),
      .chan_i  (sel_q),
      .data_i  (mux_out),
      .rdy_i   (out_rdy),
      .val_o   (out_val),
      .chan_o  (out_chan),
      .data_o  (out_data),
      .space_o (space)
   );

   assign sel        = sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_scan_ctrl_4b_8ch.sv
// Bench for mux_scan_ctrl_4b_8ch: external mux returns sel+1 on every lane,
// a cycle model is compared every negedge, directed scenarios pin literal values.
module tb_mux_scan_ctrl_4b_8ch;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       out_rdy = 1'b0;
   logic [7:0] mask = 8'h00;
   logic [3:0] mux_out;
   logic [2:0] sel;
   logic       out_val;
   logic [2:0] out_chan;
   logic [3:0] out_data;
   logic       frame_done;
   logic       busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mux_out = 4'(sel) + 4'd1;

   mux_scan_ctrl_4b_8ch dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mask       (mask),
      .sel        (sel),
      .mux_out    (mux_out),
      .out_val    (out_val),
      .out_rdy    (out_rdy),
      .out_chan   (out_chan),
      .out_data   (out_data),
      .frame_done (frame_done),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: scanning simply follows en; each scanning cycle either
   // emits the current channel, steps past a masked one, or waits for room.
   bit m_scan, m_val, m_fd, m_adv, m_took;
   int m_sel, m_chan, m_data;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_scan = 0; m_sel = 0; m_val = 0; m_chan = 0; m_data = 0; m_fd = 0;
      end else begin
         m_adv  = 0;
         m_took = 0;
         if (m_scan && en) begin
            if (!mask[m_sel]) m_adv = 1;
            else if (!m_val || out_rdy) begin
               m_val  = 1;
               m_chan = m_sel;
               m_data = (m_sel + 1) % 16;
               m_took = 1;
               m_adv  = 1;
            end
         end
         if (!m_took && m_val && out_rdy) m_val = 0;
         m_fd = m_adv && (m_sel == 7);
         if (m_adv) m_sel = (m_sel + 1) % 8;
         else if (!(m_scan && en)) m_sel = 0;
         m_scan = en;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("sel", sel, m_sel);
         check("out_val", out_val, m_val);
         check("out_chan", out_chan, m_chan);
         check("out_data", out_data, m_data);
         check("frame_done", frame_done, m_fd);
         check("busy", busy, m_scan || m_val);
      end
   end

   int qc[$];
   int qd[$];

   always @(negedge clk) begin
      if (!reset && out_val && out_rdy) begin
         qc.push_back(int'(out_chan));
         qd.push_back(int'(out_data));
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset;
      tick();
      reset = 1'b1; en = 1'b0; mask = 8'h00; out_rdy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_val(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!out_val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, out_val, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int fd_cnt;
      bit val_seen;
      int exp_sp[3];
      exp_sp[0] = 0; exp_sp[1] = 2; exp_sp[2] = 7;

      do_reset();
      check("rst_sel", sel, 0);
      check("rst_val", out_val, 0);
      check("rst_fd", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);

      // Reset while a sample is stuck behind out_rdy=0
      mask = 8'hFF; out_rdy = 1'b0; en = 1'b1;
      wait_val(20, "stall_wait");
      check("stall_chan", out_chan, 0);
      check("stall_data", out_data, 1);
      tick();
      reset = 1'b1;
      #1;
      check("async_val", out_val, 0);
      check("async_sel", sel, 0);
      check("async_fd", frame_done, 0);

      // Full-rate scan
      do_reset();
      qc.delete(); qd.delete();
      mask = 8'hFF; out_rdy = 1'b1; en = 1'b1;
      repeat (20) @(negedge clk);
      check("full_cnt", qc.size() >= 16, 1);
      for (int i = 0; i < 16 && i < qc.size(); i++) begin
         check("full_chan", qc[i], i % 8);
         check("full_data", qd[i], (i % 8) + 1);
      end

      // Sparse mask
      do_reset();
      qc.delete(); qd.delete();
      mask = 8'b1000_0101; out_rdy = 1'b1; en = 1'b1;
      repeat (30) @(negedge clk);
      check("sparse_cnt", qc.size() >= 6, 1);
      for (int i = 0; i < 6 && i < qc.size(); i++) begin
         check("sparse_chan", qc[i], exp_sp[i % 3]);
         check("sparse_data", qd[i], exp_sp[i % 3] + 1);
      end

      // Backpressure
      do_reset();
      mask = 8'hFF; out_rdy = 1'b0; en = 1'b1;
      wait_val(20, "bp_wait");
      for (int i = 0; i < 3; i++) begin
         check("bp_chan", out_chan, 0);
         check("bp_data", out_data, 1);
         check("bp_sel", sel, 1);
         if (i < 2) @(negedge clk);
      end
      tick();
      out_rdy = 1'b1;
      @(negedge clk);
      check("bp_hold_chan", out_chan, 0);
      check("bp_hold_sel", sel, 1);
      @(negedge clk);
      check("bp_next_chan", out_chan, 1);
      check("bp_next_data", out_data, 2);

      // Disable at sel=5, then re-enable
      do_reset();
      mask = 8'hFF; out_rdy = 1'b1; en = 1'b1;
      n = 0;
      @(negedge clk);
      while (sel != 3'd5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("dis_wait_sel5", sel, 5);
      check("dis_val_before", out_val, 1);
      en = 1'b0;
      @(negedge clk);
      check("dis_sel", sel, 0);
      check("dis_drained", out_val, 0);
      check("dis_busy", busy, 0);
      qc.delete(); qd.delete();
      tick();
      en = 1'b1;
      repeat (6) @(negedge clk);
      check("reen_cnt", qc.size() >= 1, 1);
      if (qc.size() >= 1) check("reen_first_chan", qc[0], 0);

      // Empty mask
      do_reset();
      mask = 8'h00; out_rdy = 1'b1; en = 1'b1;
      fd_cnt = 0;
      val_seen = 0;
      repeat (32) begin
         @(negedge clk);
         fd_cnt += int'(frame_done);
         val_seen |= out_val;
      end
      check("empty_fd_cnt", fd_cnt, 3);
      check("empty_val", val_seen, 0);
      check("empty_busy", busy, 1);
      tick();
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("empty_busy_off", busy, 0);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
